// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
//   state_t       : controller state encoding
//   DEFAULT_WIDTH : default operand width
//   cnt_width()   : iteration-counter width for a given operand width
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_idle  = 2'd0,
    S_add   = 2'd1,
    S_shift = 2'd2,
    S_done  = 2'd3
  } state_t;

  // Counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add multiplier datapath: A/B/Q/P/sgn registers plus add/sub/shift.
// Ports:
//   clk, rstb                 : clock, synchronous active-low reset
//   load, add, shift, decr    : control strobes from the controller
//   signed_mode, multiplicand,
//   multiplier                : operands, captured on load
//   p                         : remaining-iteration counter
//   shift_prod_c              : {A,Q} as it will read after the next shift
module seq_mult_dp
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            load,
  input  logic                            add,
  input  logic                            shift,
  input  logic                            decr,
  input  logic                            signed_mode,
  input  logic [WIDTH-1:0]                multiplicand,
  input  logic [WIDTH-1:0]                multiplier,
  output logic [cnt_width(WIDTH)-1:0]     p,
  output logic [2*WIDTH-1:0]              shift_prod_c
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] q;
  logic             sgn;

  logic [WIDTH:0]   b_ext;
  logic             last;
  logic             fill;

  // Zero- or sign-extend B into the (WIDTH+1)-bit accumulator width.
  assign b_ext = sgn ? {b[WIDTH-1], b} : {1'b0, b};

  // Multiplier MSB carries negative weight in signed mode.
  assign last = (p == CNT_W'(1));

  // Arithmetic shift in signed mode; unsigned shift consumes the carry bit.
  assign fill = sgn & a[WIDTH];

  // Low 2*WIDTH bits of ({A,Q} >> 1), used to capture the final product.
  assign shift_prod_c = {a, q[WIDTH-1:1]};

  // Operand/accumulator registers.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      a   <= '0;
      b   <= '0;
      q   <= '0;
      sgn <= 1'b0;
      p   <= '0;
    end else if (load) begin
      a   <= '0;
      b   <= multiplicand;
      q   <= multiplier;
      sgn <= signed_mode;
      p   <= CNT_W'(WIDTH);
    end else begin
      if (shift) begin
        a <= {fill, a[WIDTH:1]};
        q <= {a[0], q[WIDTH-1:1]};
      end else if (add && q[0]) begin
        a <= (last && sgn) ? (a - b_ext) : (a + b_ext);
      end
      if (decr) begin
        p <= p - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_mult_param.sv
// Parametrised sequential shift-add multiplier (unsigned or two's complement).
// Ports:
//   clk, rstb     : clock, synchronous active-low reset
//   start         : request, accepted only while rdy=1
//   signed_mode   : 1 = operands are two's complement (sampled with start)
//   multiplicand  : operand B (sampled with start)
//   multiplier    : operand Q (sampled with start)
//   product       : 2*WIDTH result, held from done until the next result
//   rdy           : idle or done, able to accept start
//   busy          : add/shift iterations in progress
//   done          : one-cycle pulse, product valid
module seq_mult_param
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 rdy,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t             state;
  state_t             state_nxt;
  logic               load;
  logic               add;
  logic               shift;
  logic               decr;
  logic               capture;
  logic [CNT_W-1:0]   p;
  logic [2*WIDTH-1:0] shift_prod_c;

  seq_mult_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk          (clk),
    .rstb         (rstb),
    .load         (load),
    .add          (add),
    .shift        (shift),
    .decr         (decr),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .p            (p),
    .shift_prod_c (shift_prod_c)
  );

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    add       = 1'b0;
    shift     = 1'b0;
    decr      = 1'b0;
    capture   = 1'b0;
    case (state)
      S_idle: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_add;
        end
      end
      S_add: begin
        add       = 1'b1;
        decr      = 1'b1;
        state_nxt = S_shift;
      end
      S_shift: begin
        shift = 1'b1;
        if (p == '0) begin
          capture   = 1'b1;
          state_nxt = S_done;
        end else begin
          state_nxt = S_add;
        end
      end
      S_done: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = S_add;
        end else begin
          state_nxt = S_idle;
        end
      end
      default: state_nxt = S_idle;
    endcase
  end

  // State register and registered status/product outputs.
  // The product is loaded on the edge into S_done so it is valid alongside done.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state   <= S_idle;
      rdy     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state <= state_nxt;
      rdy   <= (state_nxt == S_idle) || (state_nxt == S_done);
      busy  <= (state_nxt == S_add) || (state_nxt == S_shift);
      done  <= (state_nxt == S_done);
      if (capture) begin
        product <= shift_prod_c;
      end
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Self-checking bench for seq_mult_param: WIDTH=8 and WIDTH=4 instances,
// cycle-level transaction model plus hand-computed directed results.
module tb_seq_mult_param;

  logic        clk = 1'b0;
  logic        rstb;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  int          total = 0;
  int          passed = 0;

  logic        start8, sm8;
  logic [7:0]  b8, q8;
  logic [15:0] prod8;
  logic        rdy8, busy8, done8;

  logic        start4, sm4;
  logic [3:0]  b4, q4;
  logic [7:0]  prod4;
  logic        rdy4, busy4, done4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  seq_mult_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rstb(rstb), .start(start8), .signed_mode(sm8),
    .multiplicand(b8), .multiplier(q8), .product(prod8),
    .rdy(rdy8), .busy(busy8), .done(done8)
  );

  seq_mult_param #(.WIDTH(4)) dut4 (
    .clk(clk), .rstb(rstb), .start(start4), .signed_mode(sm4),
    .multiplicand(b4), .multiplier(q4), .product(prod4),
    .rdy(rdy4), .busy(busy4), .done(done4)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Mathematical product truncated to 2*w bits.
  function automatic logic [63:0] ref_prod(input int w, input logic s,
                                           input logic [31:0] b, input logic [31:0] q);
    longint bi, qi, r;
    bi = longint'(b);
    qi = longint'(q);
    if (s && b[w-1]) bi = bi - (longint'(1) << w);
    if (s && q[w-1]) qi = qi - (longint'(1) << w);
    r = bi * qi;
    return 64'(r) & ((64'd1 << (2 * w)) - 64'd1);
  endfunction

  // Transaction model: an accepted start yields done and the product 2*W edges later.
  int          rem8 = 0, rem4 = 0;
  logic [15:0] pend8 = '0, mprod8 = '0;
  logic [7:0]  pend4 = '0, mprod4 = '0;
  logic        mdone8 = 1'b0, mdone4 = 1'b0;

  always @(posedge clk) begin
    if (!rstb) begin
      rem8 = 0; mdone8 = 1'b0; mprod8 = '0;
    end else if (rem8 > 0) begin
      rem8--;
      mdone8 = (rem8 == 0);
      if (rem8 == 0) mprod8 = pend8;
    end else begin
      mdone8 = 1'b0;
      if (start8) begin
        rem8  = 16;
        pend8 = 16'(ref_prod(8, sm8, 32'(b8), 32'(q8)));
      end
    end
  end

  always @(posedge clk) begin
    if (!rstb) begin
      rem4 = 0; mdone4 = 1'b0; mprod4 = '0;
    end else if (rem4 > 0) begin
      rem4--;
      mdone4 = (rem4 == 0);
      if (rem4 == 0) mprod4 = pend4;
    end else begin
      mdone4 = 1'b0;
      if (start4) begin
        rem4  = 8;
        pend4 = 8'(ref_prod(4, sm4, 32'(b4), 32'(q4)));
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("done8", 64'(done8), 64'(mdone8));
      check("rdy8",  64'(rdy8),  64'(rem8 == 0));
      check("busy8", 64'(busy8), 64'(rem8 != 0));
      check("prod8", 64'(prod8), 64'(mprod8));
      check("done4", 64'(done4), 64'(mdone4));
      check("rdy4",  64'(rdy4),  64'(rem4 == 0));
      check("busy4", 64'(busy4), 64'(rem4 != 0));
      check("prod4", 64'(prod4), 64'(mprod4));
    end
  end

  task automatic wait_done8(output int at, output logic [15:0] p);
    bit found = 1'b0;
    at = 0; p = '0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (done8) begin found = 1'b1; at = cyc; p = prod8; end
    end
    if (!found) check("timeout8", 64'd0, 64'd1);
  endtask

  task automatic wait_done4(output int at, output logic [7:0] p);
    bit found = 1'b0;
    at = 0; p = '0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (done4) begin found = 1'b1; at = cyc; p = prod4; end
    end
    if (!found) check("timeout4", 64'd0, 64'd1);
  endtask

  // One operation; operands scrambled right after acceptance.
  task automatic run8(input string name, input logic s, input logic [7:0] b,
                      input logic [7:0] q, input logic [15:0] exp, output int lat);
    int acc, at;
    logic [15:0] p;
    @(negedge clk);
    start8 = 1'b1; sm8 = s; b8 = b; q8 = q;
    acc = cyc + 1;
    @(negedge clk);
    start8 = 1'b0; sm8 = ~s; b8 = ~b; q8 = ~q;
    wait_done8(at, p);
    check(name, 64'(p), 64'(exp));
    lat = at - acc;
  endtask

  task automatic run4(input string name, input logic s, input logic [3:0] b,
                      input logic [3:0] q, input logic [7:0] exp, output int lat);
    int acc, at;
    logic [7:0] p;
    @(negedge clk);
    start4 = 1'b1; sm4 = s; b4 = b; q4 = q;
    acc = cyc + 1;
    @(negedge clk);
    start4 = 1'b0; sm4 = ~s; b4 = ~b; q4 = ~q;
    wait_done4(at, p);
    check(name, 64'(p), 64'(exp));
    lat = at - acc;
  endtask

  initial begin
    int lat, at1, at2, ndone;
    logic [15:0] p;

    rstb = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; b8 = '0; q8 = '0;
    start4 = 1'b0; sm4 = 1'b0; b4 = '0; q4 = '0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    chk_en = 1'b1;

    check("rst_rdy8",  64'(rdy8),  64'd1);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod8", 64'(prod8), 64'd0);

    // Unsigned full-scale, latency and rdy during done
    run8("u255x255", 1'b0, 8'd255, 8'd255, 16'hFE01, lat);
    check("lat_u255x255", 64'(lat), 64'd16);
    check("rdy_at_done", 64'(rdy8), 64'd1);

    // Signed corner cases
    run8("s_m3x5",      1'b1, 8'hFD, 8'd5,  16'hFFF1, lat);
    run8("s_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000, lat);
    run8("s_127xm128",  1'b1, 8'h7F, 8'h80, 16'hC080, lat);

    // Back-to-back with start held through done
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; b8 = 8'd3; q8 = 8'd4;
    @(negedge clk);
    b8 = 8'd12; q8 = 8'd10;
    wait_done8(at1, p);
    check("b2b_first", 64'(p), 64'h000C);
    @(negedge clk);
    start8 = 1'b0; sm8 = 1'b1; b8 = 8'hAA; q8 = 8'h55;
    wait_done8(at2, p);
    check("b2b_second", 64'(p), 64'h0078);
    check("b2b_spacing", 64'(at2 - at1), 64'd17);

    // start pulsed while busy is ignored
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; b8 = 8'd7; q8 = 8'd9;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    start8 = 1'b1; b8 = 8'd1; q8 = 8'd1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0; p = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin ndone++; p = prod8; end
    end
    check("busy_start_ndone", 64'(ndone), 64'd1);
    check("busy_start_prod",  64'(p),     64'h003F);

    // Reset mid-operation aborts without done
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; b8 = 8'd200; q8 = 8'd3;
    @(negedge clk);
    start8 = 1'b0;
    repeat (5) @(negedge clk);
    rstb = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    check("abort_rdy",  64'(rdy8),  64'd1);
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_prod", 64'(prod8), 64'd0);
    check("abort_done", 64'(done8), 64'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    run8("u0x77", 1'b0, 8'd0, 8'h77, 16'h0000, lat);
    check("lat_u0x77", 64'(lat), 64'd16);

    // Narrow instance
    run4("w4_u15x15", 1'b0, 4'd15, 4'd15, 8'hE1, lat);
    check("lat_w4", 64'(lat), 64'd8);
    run4("w4_s_m8x7", 1'b1, 4'h8, 4'd7, 8'hC8, lat);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
Parametrised sequential shift-add multiplier, the WIDTH-generic successor of the fixed-width shift-add multiplier in the arithmetic exercises. Supports unsigned and two's-complement signed operands, selected per operation. Uses a start/rdy/done handshake with a held product register. It is a drop-in arithmetic unit for the datapath exercises that follow.

Parameters:
WIDTH, 8, operand width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), iteration-counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rstb  input  1  synchronous active-low reset
start  input  1  request; accepted only on a cycle where rdy=1
signed_mode  input  1  1 = operands two's complement; sampled with start
multiplicand  input  WIDTH  operand B; sampled with start
multiplier  input  WIDTH  operand Q; sampled with start
product  output  2*WIDTH  result; stable from done until next accepted start
rdy  output  1  1 in S_idle and S_done
busy  output  1  1 in S_add and S_shift
done  output  1  one-cycle pulse; product valid

Behaviour:
- Reset: rstb sampled low at a clk edge -> state S_idle, P=0, A=0, Q=0, B=0, sgn=0, product=0, done=0. Reset aborts any operation in flight; no done is produced for it.
- Registers:
  - A: WIDTH+1 bits; the top bit is the carry bit (unsigned) or the sign-extension bit (signed).
  - Q: WIDTH bits; B: WIDTH bits; sgn: 1 bit; P: CNT_W bits.
- FSM, states in the package enum:
  - S_idle: on start -> load A=0, B=multiplicand, Q=multiplier, sgn=signed_mode, P=WIDTH; go to S_add.
  - S_add: if Q[0]=1, A <= A + ext(B); for the last iteration (P==1) with sgn=1, A <= A - ext(B) instead. ext() zero-extends when sgn=0 and sign-extends when sgn=1. P <= P-1. Go to S_shift.
  - S_shift: {A,Q} <= {fill, A, Q} >> 1, where fill = A[WIDTH] if sgn else 0. If P==0 -> S_done, else -> S_add.
  - S_done: product <= {A[WIDTH-1:0], Q}; done=1 for this cycle only.
    - start=1: reload as in S_idle and go to S_add (back-to-back operation).
    - start=0: go to S_idle.
- Latency: with start accepted at edge k, done=1 during cycle k+2*WIDTH+1. Throughput is one result per 2*WIDTH+1 cycles.
- Unsigned carry out of the add lands in A[WIDTH]; the logical shift consumes it. No overflow is possible.
- Signed: the sign-extended (WIDTH+1)-bit sum cannot overflow. The final subtract implements the negative weight of the multiplier MSB.
- Boundaries:
  - start while busy: ignored.
  - Operand or signed_mode changes after acceptance: ignored.
  - multiplier=0: full latency, product 0.
  - product is written only in S_done and holds otherwise, including across S_idle.
- Illegal state encoding -> S_idle next cycle.

Decomposition:
- Package mult_pkg:
  - state_t enum {S_idle, S_add, S_shift, S_done};
  - default WIDTH constant;
  - localparam function computing CNT_W.
- Sub-module seq_mult_dp: holds A/B/Q/P/sgn plus the add/sub/shift logic, driven by load/add/shift/decr strobes.
- The top level holds the FSM, rdy/busy/done and the product register.

Test Plan:
1. WIDTH=8, unsigned 255×255, start at edge 0 -> done=1 in cycle 17, product=16'hFE01, rdy=1 during done.
2. WIDTH=8, signed_mode=1: -3×5 -> product=16'hFFF1; -128×-128 -> 16'h4000; 127×-128 -> 16'hC080.
3. Back-to-back: start held in S_done with unsigned 12×10 -> second done exactly 17 cycles after the first, product=16'h0078. Operands changed mid-operation do not affect the result.
4. start pulsed at cycle 5 of a busy operation -> ignored: one done only, rdy=0 and busy=1 throughout.
5. rstb low at cycle 6 of an operation -> next cycle state=S_idle, product=0, no done. A following start of 0×77 gives product=0 after full latency.
6. WIDTH=4 instance: unsigned 15×15 -> product=8'hE1 with done in cycle 9; signed -8×7 -> 8'hC8.
